// File: rtl/downstream_update_arbiter.sv
// Round-robin arbiter sharing one downstream memory-update path between N requesters;
// sequences the ack/memwr handshake, watches ds_busy and returns done (or err on timeout).
module downstream_update_arbiter #(
  parameter int N       = 4,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic            err,
  output logic            ack,
  output logic            memwr,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_data,
  input  logic            ds_busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_WAIT_BUSY,
    S_WRITE,
    S_WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic          err_q, err_d;
  logic          ack_q, ack_d;
  logic          memwr_q, memwr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;

  // Search starts at rr_ptr and wraps, so the last winner becomes lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(rr_q) + k) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every _d gets its default first, so no branch can leave one unassigned and infer a latch.
    state_d = state_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    ack_d   = 1'b0;
    memwr_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          addr_d  = req_addr[win_idx*AW +: AW];
          data_d  = req_data[win_idx*DW +: DW];
          gnt_d   = N'(1) << win_idx;
          rr_d    = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (ds_busy) begin
          memwr_d = 1'b1;
          state_d = S_WRITE;
        end else if (timer_q == T_LAST) begin
          err_d   = 1'b1;
          done_d  = gnt_q;
          gnt_d   = '0;
          state_d = S_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WRITE: begin
        timer_d = '0;
        state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (!ds_busy) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          state_d = S_IDLE;
        end else if (timer_q == T_LAST) begin
          err_d   = 1'b1;
          done_d  = gnt_q;
          gnt_d   = '0;
          state_d = S_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      timer_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      memwr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q <= state_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      memwr_q <= memwr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign ack      = ack_q;
  assign memwr    = memwr_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;

endmodule

// File: tb/tb_downstream_update_arbiter.sv
// Scoreboard bench for downstream_update_arbiter: stimulus pushes expected ack/memwr/done
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_downstream_update_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 8;

  localparam logic [AW-1:0] ADDR_TAB [N] = '{8'h20, 8'h31, 8'h10, 8'hF3};
  localparam logic [DW-1:0] DATA_TAB [N] = '{32'h1111_0000, 32'h2222_0001, 32'h0000_CAFE, 32'hDEAD_BEEF};

  typedef enum int {K_ACK, K_WR, K_DONE} kind_e;
  typedef enum int {DS_NORMAL, DS_STUCK0, DS_STUCK1} ds_mode_e;

  typedef struct {
    kind_e         kind;
    int            cyc;
    logic [N-1:0]  vec;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt, done;
  logic            err, ack, memwr;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic            ds_busy = 1'b0;

  ds_mode_e ds_mode = DS_STUCK0;
  int       cyc = 0;
  int       n_checks = 0;
  int       n_fail = 0;
  ev_t      sb[$];

  assign req_addr = {ADDR_TAB[3], ADDR_TAB[2], ADDR_TAB[1], ADDR_TAB[0]};
  assign req_data = {DATA_TAB[3], DATA_TAB[2], DATA_TAB[1], DATA_TAB[0]};

  downstream_update_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .ack      (ack),
    .memwr    (memwr),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .ds_busy  (ds_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void push(input kind_e k, input int c, input logic [N-1:0] v,
                               input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
    ev_t ev;
    ev.kind = k; ev.cyc = c; ev.vec = v; ev.addr = a; ev.data = d; ev.err = e;
    sb.push_back(ev);
  endfunction

  // Normal transaction sampled at cycle t: ack t+1, memwr t+3, done t+5.
  function automatic void push_txn(input int t, input int idx);
    logic [N-1:0] oh;
    oh = 4'b0001 << idx;
    push(K_ACK,  t + 1, oh, '0, '0, 1'b0);
    push(K_WR,   t + 3, '0, ADDR_TAB[idx], DATA_TAB[idx], 1'b0);
    push(K_DONE, t + 5, oh, '0, '0, 1'b0);
  endfunction

  task automatic observe(input kind_e k);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s @cycle %0d: got event expected none (gnt=%b done=%b err=%b)",
               k.name(), cyc, gnt, done, err);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s_kind", k.name()), k, e.kind);
      check($sformatf("%s_cycle", k.name()), cyc, e.cyc);
      case (k)
        K_ACK:  check("ack_gnt", gnt, e.vec);
        K_WR: begin
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_data, e.data);
        end
        default: begin
          check("done_vec", done, e.vec);
          check("done_err", err, e.err);
          check("done_gnt_cleared", gnt, '0);
        end
      endcase
    end
  endtask

  // Monitor: samples mid-cycle, checks invariants and consumes scoreboard entries.
  initial forever begin
    @(negedge clk);
    check("gnt_onehot0", $onehot0(gnt), 1'b1);
    check("ack_memwr_excl", ack & memwr, 1'b0);
    if (ack) observe(K_ACK);
    if (memwr) observe(K_WR);
    if (done != '0 || err) observe(K_DONE);
  end

  // Downstream processor model.
  initial forever begin
    @(negedge clk);
    case (ds_mode)
      DS_STUCK0: ds_busy = 1'b0;
      DS_STUCK1: if (ack) ds_busy = 1'b1;
      default: begin
        if (ack) ds_busy = 1'b1;
        else if (memwr) ds_busy = 1'b0;
      end
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, gnt, '0);
    check({tag, "_done"}, done, '0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_ack"}, ack, 1'b0);
    check({tag, "_memwr"}, memwr, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_mem_data"}, mem_data, '0);
  endtask

  initial begin
    int t;
    @(negedge clk);
    check_idle_outputs("reset");
    next_cycle();
    rst = 1'b0;
    ds_mode = DS_NORMAL;
    next_cycle();

    // All four requesting continuously: order 0,1,2,3,0.
    t = cyc;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_txn(t + 5 * k, k % N);
    go_to(t + 21);
    req = '0;
    go_to(t + 26);

    // Single requester 2, drops req in its done cycle.
    t = cyc;
    req = 4'b0100;
    push_txn(t, 2);
    go_to(t + 5);
    req = '0;
    go_to(t + 6);

    // ds_busy never rises: abort TIMEOUT cycles after entering WAIT_BUSY, no memwr.
    ds_mode = DS_STUCK0;
    t = cyc;
    req = 4'b0001;
    push(K_ACK,  t + 1,  4'b0001, '0, '0, 1'b0);
    push(K_DONE, t + 10, 4'b0001, '0, '0, 1'b1);
    go_to(t + 10);
    req = '0;
    ds_mode = DS_NORMAL;
    next_cycle();
    t = cyc;
    req = 4'b0010;
    push_txn(t, 1);
    go_to(t + 5);
    req = '0;
    go_to(t + 6);

    // ds_busy stuck high after the write: abort after TIMEOUT cycles in WAIT_IDLE.
    ds_mode = DS_STUCK1;
    t = cyc;
    req = 4'b1000;
    push(K_ACK,  t + 1,  4'b1000, '0, '0, 1'b0);
    push(K_WR,   t + 3,  '0, ADDR_TAB[3], DATA_TAB[3], 1'b0);
    push(K_DONE, t + 12, 4'b1000, '0, '0, 1'b1);
    go_to(t + 12);
    req = '0;
    ds_mode = DS_STUCK0;
    next_cycle();
    next_cycle();
    ds_mode = DS_NORMAL;

    // Requester 1 drops req in WAIT_BUSY while requester 3 rises.
    t = cyc;
    req = 4'b0010;
    push_txn(t, 1);
    push_txn(t + 5, 3);
    go_to(t + 2);
    req = 4'b1000;
    go_to(t + 10);
    req = '0;
    go_to(t + 11);

    // Reset during WRITE: outputs clear at once, no done, rr_ptr back to 0.
    t = cyc;
    req = 4'b0001;
    push(K_ACK, t + 1, 4'b0001, '0, '0, 1'b0);
    go_to(t + 3);
    rst = 1'b1;
    ds_mode = DS_STUCK0;
    @(negedge clk);
    check_idle_outputs("midreset");
    next_cycle();
    next_cycle();
    rst = 1'b0;
    ds_mode = DS_NORMAL;
    t = cyc;
    req = 4'b0011;
    push_txn(t, 0);
    push_txn(t + 5, 1);
    go_to(t + 5);
    req = 4'b0010;
    go_to(t + 10);
    req = '0;
    go_to(t + 11);

    repeat (5) next_cycle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) next_cycle();
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
